icache_sa: RTL

ICACHE_SA -- requirements
Module: icache_sa

---
 rtl/icache_sa_pkg.sv | 14 +
 rtl/icache_victim_sel.sv | 25 ++
 rtl/icache_sa.sv | 135 +++++++++++++
 3 files changed

// File: rtl/icache_sa_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Default geometry and refill FSM encoding.
package icache_sa_pkg;

  localparam int DEF_WAYS = 2;
  localparam int DEF_SETS = 16;
  localparam int DEF_LINE_WORDS = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

endpackage

// File: rtl/icache_victim_sel.sv
// Replacement choice for one set: lowest invalid way,
// otherwise the round-robin pointer.
module icache_victim_sel #(
  parameter int WAYS = 2,
  parameter int WW = 1
) (
  input  logic [WAYS-1:0] valid,
  input  logic [WW-1:0]   ptr,
  output logic [WW-1:0]   way
);

  logic found;

  always_comb begin
    way = ptr;
    found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid[w] && !found) begin
        way = WW'(w);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with word-by-word
// line refill from the memory controller.
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  parameter int SETS = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jp_wrong,
  input  logic        flush,
  input  logic [31:0] pc,
  output logic        ins_flag_IF,
  output logic [31:0] ins_IF,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_ack,
  input  logic [31:0] mc_data
);

  localparam int OFF = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(SETS);
  localparam int TW = 30 - OFF - IDX;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW = (OFF > 0) ? OFF : 1;
  localparam logic [31:0] LMASK = 32'(LINE_WORDS * 4 - 1);

  state_t state, state_n;

  logic [CW-1:0]  cnt, off;
  logic [IDX-1:0] idx, bidx;
  logic [TW-1:0]  tag, btag;
  logic [31:0]    base;
  logic [WW-1:0]  vway, hway, victim;
  logic           hit, start, deliver;
  logic           fill_ack, last;

  logic [WAYS-1:0] valid [SETS];
  logic [WW-1:0]   ptr   [SETS];
  logic [TW-1:0]   tags  [SETS][WAYS];
  logic [31:0]     data  [SETS][WAYS][LINE_WORDS];

  assign off  = CW'((pc >> 2) & 32'(LINE_WORDS - 1));
  assign idx  = IDX'(pc >> (OFF + 2));
  assign tag  = TW'(pc >> (OFF + IDX + 2));
  assign bidx = IDX'(base >> (OFF + 2));
  assign btag = TW'(base >> (OFF + IDX + 2));

  always_comb begin
    hit = 1'b0;
    hway = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit = 1'b1;
        hway = WW'(w);
      end
    end
  end

  icache_victim_sel #(
    .WAYS (WAYS),
    .WW   (WW)
  ) u_victim (
    .valid (valid[idx]),
    .ptr   (ptr[idx]),
    .way   (victim)
  );

  assign last     = (cnt == CW'(LINE_WORDS - 1));
  assign fill_ack = (state == REFILL) && mc_ack;
  assign start    = (state == IDLE) && !hit && !jp_wrong && !flush;
  assign deliver  = (state == IDLE) && hit && !jp_wrong;

  assign mc_req  = (state == REFILL);
  assign mc_addr = mc_req ? base + (32'(cnt) << 2) : 32'h0;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = REFILL;
      REFILL: if (flush || (mc_ack && last)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      vway <= '0;
      ins_flag_IF <= 1'b0;
      ins_IF <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        ptr[s] <= '0;
      end
    end else if (rdy) begin
      state <= state_n;
      ins_flag_IF <= deliver;
      if (deliver) ins_IF <= data[idx][hway][off];
      if (flush) begin
        cnt <= '0;
        for (int s = 0; s < SETS; s++) begin
          valid[s] <= '0;
          ptr[s] <= '0;
        end
      end else if (start) begin
        // victim stays invalid until the whole line is in
        base <= pc & ~LMASK;
        vway <= victim;
        cnt <= '0;
        valid[idx][victim] <= 1'b0;
      end else if (fill_ack) begin
        cnt <= cnt + 1'b1;
        if (last) begin
          cnt <= '0;
          valid[bidx][vway] <= 1'b1;
          ptr[bidx] <= (vway == WW'(WAYS - 1)) ? '0 : vway + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush && fill_ack) begin
      data[bidx][vway][cnt] <= mc_data;
      if (last) tags[bidx][vway] <= btag;
    end
  end

endmodule
